fb_snapshot_scheduler: RTL and testbench
========================================

Name: fb_snapshot_scheduler

Overview:
Owns the single frame-buffer read port and shares it between the VGA display path and a snapshot dumper.
- Display reads always win while den is high.
- On a capture trigger (cap_val pulse from the VGA memory controller), the block waits for the end of the current active frame. It then streams all 320x240 stored pixels out over a valid/ready interface, issuing reads only in blanking cycles.
- Sits between the VGA timing/memory controller and the frame buffer; the stream feeds the export/UART path.

Parameters:
H_ACT, 640, active pixels per line on screen
V_ACT, 480, active lines on screen
FB_W, 320, frame-buffer width (display upscales 2x)
FB_H, 240, frame-buffer height
ADDR_W, 17, frame-buffer address width

Ports:
clk  input  1  system clock (pixel clock domain)
reset  input  1  synchronous, active-high reset
den  input  1  display read enable (active video area)
x_pixel  input  10  current VGA column
y_pixel  input  10  current VGA row
cap_trig  input  1  single-cycle snapshot request
rAddr  output  ADDR_W  frame-buffer read address
rData  input  16  frame-buffer read data, RGB565, valid 1 cycle after address
snap_data  output  16  snapshot pixel
snap_valid  output  1  snap_data valid
snap_ready  input  1  downstream accepts beat when valid&ready
snap_sof  output  1  high with first beat (address 0)
snap_eof  output  1  high with last beat (address FB_W*FB_H-1)
busy  output  1  high in any state except IDLE
overrun  output  1  sticky: trigger arrived while busy
done  output  1  one-cycle pulse after last beat accepted
fb_freeze  output  1  request to frame-buffer writer to stop writing

Behaviour:
Reset state:
- Reset is synchronous, active-high; the clock is clk. All state and registers clear on the reset edge, including mid-dump: the state machine returns to IDLE and any in-flight read is discarded.
- Every registered output resets to 0: snap_valid, snap_sof, snap_eof, snap_data, busy, overrun, done, fb_freeze.

Read-port mux (combinational):
- den=1: rAddr = (y_pixel/2)*FB_W + x_pixel/2.
- den=0 and issue=1: rAddr = dump_addr.
- Otherwise rAddr = 0.
- issue = (state==DUMP) & !den & !pend & !snap_valid.

Read pipeline:
- pend is set the cycle after issue and cleared the following cycle.
- When pend=1: snap_data<=rData, snap_valid<=1, snap_sof<=(data addr==0), snap_eof<=(data addr==FB_W*FB_H-1).
- dump_addr increments on issue.
- snap_valid holds, with data stable, until valid&ready. On acceptance, snap_valid, snap_sof and snap_eof clear.
- Result: at most one outstanding read; at most 1 beat per 3 cycles.

State machine:
- IDLE: on cap_trig -> WAIT_FRAME. Clear overrun, set dump_addr=0.
- WAIT_FRAME: on the cycle x_pixel==H_ACT-1 && y_pixel==V_ACT-1 -> DUMP.
- DUMP: issue reads per the rule above. When the eof beat is accepted -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.

Triggers and timing rules:
- cap_trig in any state other than IDLE is ignored and sets overrun=1.
- A trigger in the same cycle as the DONE->IDLE transition is also ignored and sets overrun.
- Display always has priority: no dump read is ever issued while den=1.
- den rising in the cycle after issue does not corrupt data; the read address was sampled at the issue edge.
- A dump spans many frames. A trigger arriving exactly on the frame-end cycle still waits for the next frame end.

Arithmetic:
- dump_addr is ADDR_W bits and never exceeds 76799.
- The display address product is computed in ADDR_W bits with no truncation: the maximum is 239*320+319 = 76799.

Optional Feature:
FB_FREEZE_EN
- Defined: fb_freeze=1 from entry into DUMP until the DONE cycle inclusive, so the stored image is coherent.
- Undefined: fb_freeze is tied 0; the writer may update pixels mid-dump and the dump may tear.

Test Plan:
1. Reset, hold 10 cycles -> all outputs 0, state IDLE. With den=1, x=10, y=4 -> rAddr=2*320+5=645.
2. cap_trig pulse at y=100 -> busy=1 next cycle. No snap_valid before x=639,y=479. First beat has snap_sof=1, rData taken from address 0.
3. Run a dump with snap_ready=1 and a VGA timing model -> no issue cycle while den=1. rAddr always equals the display address when den=1. Exactly 76800 beats, eof only on beat 76800, done pulses once, busy drops.
4. snap_ready=0 for 50 cycles mid-dump -> snap_valid and snap_data held constant, no new reads issued. Releasing ready resumes with the next sequential address.
5. Second cap_trig during DUMP -> overrun=1, dump unaffected. Next trigger in IDLE clears overrun.
6. Assert reset at beat 1000 -> next cycle state IDLE and all outputs 0. A fresh trigger restarts the dump at address 0. With FB_FREEZE_EN defined, fb_freeze is high through DUMP; without it, fb_freeze is always 0.

Source files
------------

// File: rtl/fb_snapshot_scheduler.sv
// fb_snapshot_scheduler
//   Owns the single frame-buffer read port. The VGA display path reads whenever den is high.
//   A snapshot dumper streams the whole stored frame out on a valid/ready interface. After a
//   capture trigger it waits for the end of the current active frame, then issues its reads
//   only in blanking cycles.
//
// Optional build macro:
//   FB_FREEZE_EN  when defined, fb_freeze is high from entry into DUMP through the DONE cycle.
//                 When undefined, fb_freeze is tied low.
//
// Ports:
//   clk, reset           pixel clock, synchronous active-high reset
//   den, x_pixel/y_pixel VGA active-area enable and current column/row
//   cap_trig             single-cycle snapshot request
//   rAddr / rData        frame-buffer read port (data valid one cycle after address)
//   snap_*               snapshot stream (data, valid, ready, first/last beat markers)
//   busy, overrun, done  status: not idle, sticky ignored trigger, end-of-dump pulse
//   fb_freeze            asks the frame-buffer writer to hold off during a dump
module fb_snapshot_scheduler #(
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned FB_W   = 320,
  parameter int unsigned FB_H   = 240,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              den,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              cap_trig,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [15:0]       rData,
  output logic [15:0]       snap_data,
  output logic              snap_valid,
  input  logic              snap_ready,
  output logic              snap_sof,
  output logic              snap_eof,
  output logic              busy,
  output logic              overrun,
  output logic              done,
  output logic              fb_freeze
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {StIdle, StWaitFrame, StDump, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;  // address of the read currently in flight
  logic              pend_q, pend_d;
  logic              snap_valid_q, snap_valid_d;
  logic              snap_sof_q, snap_sof_d;
  logic              snap_eof_q, snap_eof_d;
  logic [15:0]       snap_data_q, snap_data_d;
  logic              overrun_q, overrun_d;

  logic              issue;
  logic              accept;
  logic              frame_end;
  logic [ADDR_W-1:0] disp_addr;

  // Display upscales 2x, so halve the VGA coordinates before indexing the buffer.
  assign disp_addr = ADDR_W'(y_pixel[9:1]) * ADDR_W'(FB_W) + ADDR_W'(x_pixel[9:1]);
  assign frame_end = (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));

  always_comb begin
    // One read in flight at most, and only when the output register is free.
    issue  = (state_q == StDump) && !den && !pend_q && !snap_valid_q;
    accept = snap_valid_q && snap_ready;

    if (den) begin
      rAddr = disp_addr;
    end else if (issue) begin
      rAddr = dump_addr_q;
    end else begin
      rAddr = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    overrun_d   = overrun_q;

    case (state_q)
      StIdle: begin
        if (cap_trig) begin
          state_d     = StWaitFrame;
          overrun_d   = 1'b0;
          dump_addr_d = '0;
        end
      end
      StWaitFrame: if (frame_end) state_d = StDump;
      StDump:      if (accept && snap_eof_q) state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase

    if (cap_trig && (state_q != StIdle)) overrun_d = 1'b1;

    // Saturate so the counter stays inside the frame after the last read.
    if (issue && (dump_addr_q != LastAddr)) dump_addr_d = dump_addr_q + 1'b1;
  end

  always_comb begin
    pend_d       = issue;
    rd_addr_d    = issue ? dump_addr_q : rd_addr_q;
    snap_valid_d = snap_valid_q;
    snap_sof_d   = snap_sof_q;
    snap_eof_d   = snap_eof_q;
    snap_data_d  = snap_data_q;

    if (accept) begin
      snap_valid_d = 1'b0;
      snap_sof_d   = 1'b0;
      snap_eof_d   = 1'b0;
    end
    // rData belongs to the address presented on the issue cycle, whatever rAddr shows now.
    if (pend_q) begin
      snap_data_d  = rData;
      snap_valid_d = 1'b1;
      snap_sof_d   = (rd_addr_q == '0);
      snap_eof_d   = (rd_addr_q == LastAddr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dump_addr_q  <= '0;
      rd_addr_q    <= '0;
      pend_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_sof_q   <= 1'b0;
      snap_eof_q   <= 1'b0;
      snap_data_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_addr_q  <= dump_addr_d;
      rd_addr_q    <= rd_addr_d;
      pend_q       <= pend_d;
      snap_valid_q <= snap_valid_d;
      snap_sof_q   <= snap_sof_d;
      snap_eof_q   <= snap_eof_d;
      snap_data_q  <= snap_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;
  assign snap_sof   = snap_sof_q;
  assign snap_eof   = snap_eof_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

`ifdef FB_FREEZE_EN
  assign fb_freeze  = (state_q == StDump) || (state_q == StDone);
`else
  assign fb_freeze  = 1'b0;
`endif

endmodule

// File: tb/tb_fb_snapshot_scheduler.sv
// Scoreboard bench: a reduced-geometry instance runs full dumps against a randomly filled
// frame-buffer model. A full-size instance checks the display address arithmetic.
module tb_fb_snapshot_scheduler;

  localparam int HA = 16, VA = 12, FW = 8, FH = 6, AW = 17;
  localparam int HT = 20, VT = 15;
  localparam int NPIX = FW * FH;
`ifdef FB_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          den;
  logic [9:0]    x_pixel, y_pixel;
  logic          cap_trig = 1'b0;
  logic [AW-1:0] rAddr;
  logic [15:0]   rData = 16'h0;
  logic [15:0]   snap_data;
  logic          snap_valid, snap_ready = 1'b0, snap_sof, snap_eof;
  logic          busy, overrun, done, fb_freeze;

  // Full-size instance for the display-address check.
  logic          den2 = 1'b0;
  logic [9:0]    x2 = '0, y2 = '0;
  logic [16:0]   r2;
  logic [15:0]   sd2;
  logic          sv2, sof2, eof2, busy2, ovr2, done2, frz2;

  int    tests = 0, fails = 0;
  int    hx = 0, vy = 0;
  logic [15:0] mem [NPIX];
  beat_t q[$];
  int    m_phase = 0;  // 0 idle, 1 waiting for frame end, 2 dumping, 3 done
  bit    m_ovr = 1'b0;
  int    acc = 0;
  bit    mon_en = 1'b0;
  bit    stall = 1'b0;
  bit    hold_prev = 1'b0;
  logic [15:0] hold_data = 16'h0;

  fb_snapshot_scheduler #(
    .H_ACT(HA), .V_ACT(VA), .FB_W(FW), .FB_H(FH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .den(den), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .cap_trig(cap_trig), .rAddr(rAddr), .rData(rData), .snap_data(snap_data),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_sof(snap_sof),
    .snap_eof(snap_eof), .busy(busy), .overrun(overrun), .done(done), .fb_freeze(fb_freeze)
  );

  fb_snapshot_scheduler dut_full (
    .clk(clk), .reset(reset), .den(den2), .x_pixel(x2), .y_pixel(y2),
    .cap_trig(1'b0), .rAddr(r2), .rData(16'h0), .snap_data(sd2),
    .snap_valid(sv2), .snap_ready(1'b0), .snap_sof(sof2),
    .snap_eof(eof2), .busy(busy2), .overrun(ovr2), .done(done2), .fb_freeze(frz2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reduced VGA timing.
  always @(posedge clk) begin
    if (hx == HT - 1) begin
      hx <= 0;
      vy <= (vy == VT - 1) ? 0 : vy + 1;
    end else begin
      hx <= hx + 1;
    end
  end
  assign x_pixel = 10'(hx);
  assign y_pixel = 10'(vy);
  assign den     = (hx < HA) && (vy < VA);

  // Frame buffer with one-cycle read latency.
  always @(posedge clk) rData <= (int'(rAddr) < NPIX) ? mem[int'(rAddr)] : 16'h0;

  always @(posedge clk) begin
    #1;
    snap_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
  end

  // Reference model: dump lifecycle, overrun and the expected beat stream.
  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_ovr   <= 1'b0;
      q.delete();
    end else begin
      if (cap_trig && m_phase != 0) m_ovr <= 1'b1;
      case (m_phase)
        0: if (cap_trig) begin
          m_phase <= 1;
          m_ovr   <= 1'b0;
          for (int a = 0; a < NPIX; a++) begin
            beat_t b;
            b.d = mem[a];
            b.sof = (a == 0);
            b.eof = (a == NPIX - 1);
            q.push_back(b);
          end
        end
        1: if (hx == HA - 1 && vy == VA - 1) m_phase <= 2;
        2: if (acc == NPIX) m_phase <= 3;
        default: m_phase <= 0;
      endcase
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (den) chk("rAddr_display", int'(rAddr), (vy / 2) * FW + hx / 2);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
      chk("overrun", overrun, m_ovr);
      chk("fb_freeze", fb_freeze, FREEZE && m_phase >= 2);
      if (m_phase <= 1) chk("valid_before_dump", snap_valid, 0);
      if (m_phase == 3) chk("beats_remaining", q.size(), 0);
      if (hold_prev) begin
        chk("hold_valid", snap_valid, 1);
        chk("hold_data", snap_data, hold_data);
      end
      hold_prev = 1'b0;
      if (reset || m_phase == 1) acc = 0;
      if (!reset && snap_valid) begin
        if (snap_ready) begin
          if (q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            beat_t e;
            e = q.pop_front();
            chk("beat_data", snap_data, e.d);
            chk("beat_sof", snap_sof, e.sof);
            chk("beat_eof", snap_eof, e.eof);
            acc++;
          end
        end else begin
          hold_prev = 1'b1;
          hold_data = snap_data;
        end
      end
    end
  end

  task automatic pulse_trig();
    @(posedge clk); #1 cap_trig = 1'b1;
    @(posedge clk); #1 cap_trig = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_phase != ph) chk(name, m_phase, ph);
  endtask

  task automatic wait_acc(input int cnt, input int budget);
    int n = 0;
    while (acc < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc < cnt) chk("wait_beats_timeout", acc, cnt);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, snap_valid, 0);
    chk({tag, "_sof"}, snap_sof, 0);
    chk({tag, "_eof"}, snap_eof, 0);
    chk({tag, "_data"}, snap_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_freeze"}, fb_freeze, 0);
  endtask

  initial begin
    int x, y;
    for (int a = 0; a < NPIX; a++) mem[a] = 16'($urandom);

    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    chk("full_valid", sv2, 0);
    chk("full_busy", busy2, 0);
    chk("full_flags", {sof2, eof2, ovr2, done2, frz2}, 0);
    chk("full_data", sd2, 0);

    den2 = 1'b1; x2 = 10'd10; y2 = 10'd4; #1;
    chk("disp_addr_10_4", int'(r2), 645);
    x2 = 10'd639; y2 = 10'd479; #1;
    chk("disp_addr_max", int'(r2), 76799);
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(639);
      y = $urandom_range(479);
      x2 = 10'(x); y2 = 10'(y); #1;
      chk("disp_addr_rand", int'(r2), (y / 2) * 320 + x / 2);
    end
    den2 = 1'b0; #1;
    chk("idle_addr_zero", int'(r2), 0);

    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Trigger mid-frame, stall mid-dump, and a second trigger while busy.
    while (vy != 5) begin @(posedge clk); #1; end
    pulse_trig();
    wait_phase(2, 2000, "enter_dump_timeout");
    wait_acc(10, 3000);
    stall = 1'b1;
    repeat (50) @(posedge clk);
    #1 stall = 1'b0;
    pulse_trig();
    chk("overrun_set", overrun, 1);
    wait_phase(3, 5000, "dump1_done_timeout");
    wait_phase(0, 10, "dump1_idle_timeout");

    // Trigger exactly on the frame-end cycle; this also clears overrun.
    while (!(hx == HA - 1 && vy == VA - 1)) begin @(posedge clk); #1; end
    cap_trig = 1'b1;
    @(posedge clk); #1 cap_trig = 1'b0;
    chk("overrun_cleared", overrun, 0);
    wait_phase(2, 2000, "enter_dump2_timeout");
    wait_phase(3, 5000, "dump2_done_timeout");
    // Trigger landing on the DONE cycle counts as overrun.
    cap_trig = 1'b1;
    @(posedge clk); #1 cap_trig = 1'b0;
    chk("overrun_on_done", overrun, 1);
    wait_phase(0, 10, "dump2_idle_timeout");

    // Reset in the middle of a dump, then restart from address 0.
    pulse_trig();
    wait_acc(20, 5000);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk_outputs_zero("midreset");
    pulse_trig();
    wait_phase(3, 6000, "dump3_done_timeout");
    wait_phase(0, 10, "dump3_idle_timeout");
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
